// File: rtl/packet_encoder.sv
// USB-style low-level packet transmitter: SYNC, PID, optional payload + CRC16, EOP, with NRZI and bit stuffing.
// Define PACKET_ENCODER_ABORT_EN to abort a starved payload with a stuff-error pattern instead of closing it with a CRC.
`timescale 1ns/1ps
module packet_encoder (
    input  logic       clk48,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic       tx_zlp,
    input  logic [7:0] tx_byte,
    input  logic       tx_byte_valid,
    input  logic       tx_byte_last,
    output logic       tx_byte_ready,
    output logic       dp_out,
    output logic       dn_out,
    output logic       tx_oe,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_ABORT, S_EOP_SE0, S_EOP_J
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [3:0]  idx_q, idx_d;
    logic [2:0]  ones_q, ones_d;
    logic        stuff_q, stuff_d;
    logic        line_q, line_d;      // 1 = J, 0 = K
    logic [3:0]  pid_q, pid_d;
    logic        zlp_q, zlp_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic [15:0] crc_q, crc_d;
    logic        done_q, done_d;

    logic        strobe;
    logic        stuffable;
    logic        cur_bit;
    logic        nxt_bit;
    logic        stuff_now;
    logic        need_byte;
    logic        crc_fb;
    logic [7:0]  pid_byte;

    assign pid_byte = {~pid_q, pid_q};
    assign strobe   = (state_q != S_IDLE) && (cnt_q == 2'd3);
    assign stuffable = (state_q == S_SYNC) || (state_q == S_PID) ||
                       (state_q == S_DATA) || (state_q == S_CRC);

    // Data value of the bit currently on the line.
    always_comb begin
        cur_bit = 1'b0;
        if (!stuff_q) begin
            case (state_q)
                S_SYNC:  cur_bit = (idx_q == 4'd7);
                S_PID:   cur_bit = pid_byte[idx_q[2:0]];
                S_DATA:  cur_bit = byte_q[idx_q[2:0]];
                S_CRC:   cur_bit = ~crc_q[idx_q];
                S_ABORT: cur_bit = 1'b1;
                default: cur_bit = 1'b0;
            endcase
        end
    end

    assign stuff_now = strobe && stuffable && !stuff_q && cur_bit && (ones_q == 3'd5);
    assign crc_fb    = crc_q[0] ^ cur_bit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == S_IDLE) ? 2'd0 : cnt_q + 2'd1;
        idx_d     = idx_q;
        ones_d    = ones_q;
        stuff_d   = stuff_q;
        line_d    = line_q;
        pid_d     = pid_q;
        zlp_d     = zlp_q;
        byte_d    = byte_q;
        last_d    = last_q;
        crc_d     = crc_q;
        done_d    = 1'b0;
        need_byte = 1'b0;
        nxt_bit   = 1'b1;

        if (state_q == S_IDLE) begin
            if (tx_start) begin
                state_d = S_SYNC;
                cnt_d   = 2'd0;
                idx_d   = 4'd0;
                ones_d  = 3'd0;
                stuff_d = 1'b0;
                line_d  = 1'b0;   // first SYNC bit is a 0: J -> K
                pid_d   = tx_pid;
                zlp_d   = tx_zlp;
                crc_d   = 16'hFFFF;
            end
        end else if (strobe) begin
            // Account for the bit that just finished.
            if (stuffable && !stuff_q)
                ones_d = cur_bit ? ones_q + 3'd1 : 3'd0;
            else
                ones_d = 3'd0;
            if (state_q == S_DATA && !stuff_q)
                crc_d = {1'b0, crc_q[15:1]} ^ (crc_fb ? 16'hA001 : 16'h0000);

            if (stuff_now) begin
                // Field position holds; the stuffed 0 occupies this bit time.
                stuff_d = 1'b1;
                ones_d  = 3'd0;
                line_d  = ~line_q;
            end else begin
                stuff_d = 1'b0;
                idx_d   = idx_q + 4'd1;
                case (state_q)
                    S_SYNC: if (idx_q == 4'd7) begin
                        state_d = S_PID;
                        idx_d   = 4'd0;
                    end
                    S_PID: if (idx_q == 4'd7) begin
                        idx_d = 4'd0;
                        if (pid_q[2:0] != 3'b011)
                            state_d = S_EOP_SE0;
                        else if (zlp_q)
                            state_d = S_CRC;
                        else
                            need_byte = 1'b1;
                    end
                    S_DATA: if (idx_q == 4'd7) begin
                        idx_d = 4'd0;
                        if (last_q)
                            state_d = S_CRC;
                        else
                            need_byte = 1'b1;
                    end
                    S_CRC: if (idx_q == 4'd15) begin
                        state_d = S_EOP_SE0;
                        idx_d   = 4'd0;
                    end
                    S_ABORT: if (idx_q == 4'd7) begin
                        state_d = S_EOP_SE0;
                        idx_d   = 4'd0;
                    end
                    S_EOP_SE0: if (idx_q == 4'd1) begin
                        state_d = S_EOP_J;
                        idx_d   = 4'd0;
                    end
                    S_EOP_J: begin
                        state_d = S_IDLE;
                        idx_d   = 4'd0;
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase

                if (need_byte) begin
                    if (tx_byte_valid) begin
                        state_d = S_DATA;
                        byte_d  = tx_byte;
                        last_d  = tx_byte_last;
                    end else begin
`ifdef PACKET_ENCODER_ABORT_EN
                        state_d = S_ABORT;
`else
                        state_d = S_CRC;
`endif
                    end
                end

                // Data value of the bit that starts now, then NRZI onto the line.
                case (state_d)
                    S_SYNC:  nxt_bit = (idx_d == 4'd7);
                    S_PID:   nxt_bit = pid_byte[idx_d[2:0]];
                    S_DATA:  nxt_bit = byte_d[idx_d[2:0]];
                    S_CRC:   nxt_bit = ~crc_d[idx_d];
                    default: nxt_bit = 1'b1;
                endcase
                if (state_d == S_SYNC || state_d == S_PID || state_d == S_DATA ||
                    state_d == S_CRC || state_d == S_ABORT)
                    line_d = nxt_bit ? line_q : ~line_q;
                else
                    line_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk48 or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            idx_q   <= 4'd0;
            ones_q  <= 3'd0;
            stuff_q <= 1'b0;
            line_q  <= 1'b1;
            pid_q   <= 4'd0;
            zlp_q   <= 1'b0;
            byte_q  <= 8'd0;
            last_q  <= 1'b0;
            crc_q   <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ones_q  <= ones_d;
            stuff_q <= stuff_d;
            line_q  <= line_d;
            pid_q   <= pid_d;
            zlp_q   <= zlp_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            crc_q   <= crc_d;
            done_q  <= done_d;
        end
    end

    assign tx_oe         = (state_q != S_IDLE);
    assign tx_busy       = (state_q != S_IDLE);
    assign tx_done       = done_q;
    assign tx_byte_ready = need_byte;
    assign tx_underrun   = need_byte && !tx_byte_valid;
    assign dp_out        = !tx_oe || ((state_q != S_EOP_SE0) && line_q);
    assign dn_out        = tx_oe && (state_q != S_EOP_SE0) && !line_q;

endmodule

// File: tb/tb_packet_encoder.sv
// Directed bench for packet_encoder: decodes the NRZI line into raw bits and checks them against hand-built vectors.
`timescale 1ns/1ps
module tb_packet_encoder;

    logic       clk48 = 1'b0;
    logic       reset = 1'b0;
    logic       tx_start = 1'b0;
    logic [3:0] tx_pid = 4'd0;
    logic       tx_zlp = 1'b0;
    logic [7:0] tx_byte = 8'd0;
    logic       tx_byte_valid = 1'b0;
    logic       tx_byte_last = 1'b0;
    logic       tx_byte_ready, dp_out, dn_out, tx_oe, tx_busy, tx_done, tx_underrun;

    int n_tests = 0;
    int n_fail  = 0;

    packet_encoder dut (
        .clk48         (clk48),
        .reset         (reset),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .tx_zlp        (tx_zlp),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid),
        .tx_byte_last  (tx_byte_last),
        .tx_byte_ready (tx_byte_ready),
        .dp_out        (dp_out),
        .dn_out        (dn_out),
        .tx_oe         (tx_oe),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_underrun   (tx_underrun)
    );

    always #10 clk48 = ~clk48;

    // Payload source
    logic [7:0] pay [4];
    int  n_bytes, n_avail, byte_idx;
    bit  xfer_pend;

    // Line monitor
    bit           mon_on;
    int           mon_n;
    logic [127:0] raw_vec;
    int           raw_cnt;
    logic [7:0]   lvl_vec;
    logic         prev_lvl;
    int           se0_cnt, j_cnt, done_cnt, done_n, rdy_cnt, und_cnt;
    bit           seen_se0;
    int           rdy_n [8];

    bit ds [128];
    int ds_cnt, stuff_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic drive_feed();
        tx_byte       = pay[(byte_idx < 4) ? byte_idx : 0];
        tx_byte_last  = (byte_idx == n_bytes - 1);
        tx_byte_valid = (byte_idx < n_avail);
    endtask

    always @(negedge clk48) begin
        if (xfer_pend) begin
            xfer_pend = 1'b0;
            byte_idx++;
            drive_feed();
        end
        if (mon_on) begin
            if (tx_byte_ready) begin
                if (rdy_cnt < 8) rdy_n[rdy_cnt] = mon_n;
                rdy_cnt++;
                if (tx_byte_valid) xfer_pend = 1'b1;
            end
            if (tx_underrun) und_cnt++;
            if (tx_done) begin
                done_cnt++;
                if (done_cnt == 1) done_n = mon_n;
            end
            if (tx_oe) begin
                if (!dp_out && !dn_out) begin
                    se0_cnt++;
                    seen_se0 = 1'b1;
                end else if (seen_se0) begin
                    if (dp_out && !dn_out) j_cnt++;
                end else if (mon_n % 4 == 1) begin
                    if (raw_cnt < 128) raw_vec[raw_cnt] = (dp_out == prev_lvl);
                    if (raw_cnt < 8) lvl_vec[raw_cnt] = dp_out;
                    prev_lvl = dp_out;
                    raw_cnt++;
                end
            end
            mon_n++;
        end
    end

    task automatic start_pkt(input logic [3:0] pid, input logic zlp);
        byte_idx  = 0;
        xfer_pend = 1'b0;
        drive_feed();
        raw_vec  = '0;
        raw_cnt  = 0;
        lvl_vec  = '0;
        prev_lvl = 1'b1;
        se0_cnt  = 0;
        j_cnt    = 0;
        seen_se0 = 1'b0;
        done_cnt = 0;
        done_n   = -1;
        rdy_cnt  = 0;
        und_cnt  = 0;
        @(negedge clk48);
        tx_pid   = pid;
        tx_zlp   = zlp;
        tx_start = 1'b1;
        @(posedge clk48);
        #1;
        tx_start = 1'b0;
        mon_n    = 0;
        mon_on   = 1'b1;
    endtask

    // ign_at >= 0 pulses tx_start again that many cycles in, which must be ignored.
    task automatic run_pkt(input logic [3:0] pid, input logic zlp, input int ign_at);
        start_pkt(pid, zlp);
        for (int c = 0; c < 2000 && done_cnt == 0; c++) begin
            @(negedge clk48);
            tx_start = (c == ign_at);
        end
        tx_start = 1'b0;
        repeat (8) @(negedge clk48);
        mon_on = 1'b0;
    endtask

    task automatic destuff();
        int ones;
        ones      = 0;
        ds_cnt    = 0;
        stuff_err = 0;
        for (int i = 0; i < raw_cnt && i < 128; i++) begin
            if (ones == 6) begin
                if (raw_vec[i]) stuff_err++;
                ones = 0;
            end else begin
                ds[ds_cnt] = raw_vec[i];
                ds_cnt++;
                ones = raw_vec[i] ? ones + 1 : 0;
            end
        end
    endtask

    // Receiver-side CRC over payload+CRC bits in wire order; a good packet leaves 0x800D.
    function automatic logic [15:0] crc_resid(input int from);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = from; i < ds_cnt; i++) begin
            fb = c[15] ^ ds[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h8005;
        end
        return c;
    endfunction

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_dp"},    dp_out,        1'b1);
        check({pfx, "_dn"},    dn_out,        1'b0);
        check({pfx, "_oe"},    tx_oe,         1'b0);
        check({pfx, "_busy"},  tx_busy,       1'b0);
        check({pfx, "_done"},  tx_done,       1'b0);
        check({pfx, "_ready"}, tx_byte_ready, 1'b0);
        check({pfx, "_under"}, tx_underrun,   1'b0);
    endtask

    initial begin
        logic [41:0] ff_exp;
        ff_exp  = {17'h1BF00, 9'h1EF, 8'hC3, 8'h80};
        n_bytes = 0;
        n_avail = 0;
        byte_idx = 0;
        for (int i = 0; i < 4; i++) pay[i] = 8'h00;
        drive_feed();

        repeat (3) @(negedge clk48);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk48);

        // ACK, with a second tx_start during SYNC that must be ignored
        run_pkt(4'h2, 1'b0, 20);
        check("ack_raw",      raw_vec[15:0], 16'hD280);
        check("ack_nbits",    raw_cnt,       16);
        check("ack_syncline", lvl_vec,       8'h2A);
        check("ack_se0",      se0_cnt,       8);
        check("ack_j",        j_cnt,         4);
        check("ack_done_at",  done_n,        76);
        check("ack_done_cnt", done_cnt,      1);
        check("ack_ready",    rdy_cnt,       0);
        check("ack_oe_after", tx_oe,         1'b0);

        // Non-handshake, non-data PID: SYNC + PID + EOP only
        run_pkt(4'h5, 1'b0, -1);
        check("pid5_raw",     raw_vec[15:0], 16'hA580);
        check("pid5_nbits",   raw_cnt,       16);
        check("pid5_done_at", done_n,        76);

        // DATA0 zero-length
        run_pkt(4'h3, 1'b1, -1);
        check("zlp_raw",     raw_vec[31:0], 32'h0000C380);
        check("zlp_nbits",   raw_cnt,       32);
        check("zlp_done_at", done_n,        140);
        destuff();
        check("zlp_resid",   crc_resid(16), 16'h800D);

        // DATA0 with a single 0xFF byte: stuffed 0 after its 4th bit, and in the CRC
        pay[0]  = 8'hFF;
        n_bytes = 1;
        n_avail = 1;
        run_pkt(4'h3, 1'b0, -1);
        check("ff_raw",      raw_vec[41:0], ff_exp);
        check("ff_nbits",    raw_cnt,       42);
        check("ff_ready",    rdy_cnt,       1);
        check("ff_ready_at", rdy_n[0],      63);
        check("ff_done_at",  done_n,        180);

        // DATA1 with four bytes, valid held high
        pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03; pay[3] = 8'h04;
        n_bytes = 4;
        n_avail = 4;
        run_pkt(4'hB, 1'b0, -1);
        check("d1_pid",      raw_vec[15:0],       16'h4B80);
        check("d1_ready",    rdy_cnt,             4);
        check("d1_ready_at", rdy_n[0],            63);
        check("d1_gap1",     rdy_n[1] - rdy_n[0], 32);
        check("d1_gap2",     rdy_n[2] - rdy_n[1], 32);
        check("d1_gap3",     rdy_n[3] - rdy_n[2], 32);
        check("d1_under",    und_cnt,             0);
        destuff();
        check("d1_ds_bits",  ds_cnt,              64);
        check("d1_stufferr", stuff_err,           0);
        check("d1_resid",    crc_resid(16),       16'h800D);

        // DATA0, valid dropped before byte 2
        pay[0] = 8'h5A; pay[1] = 8'h33;
        n_bytes = 3;
        n_avail = 1;
        run_pkt(4'h3, 1'b0, -1);
        check("ur_under",    und_cnt,  1);
        check("ur_ready",    rdy_cnt,  2);
        check("ur_ready_at", rdy_n[1], 95);
        check("ur_done_cnt", done_cnt, 1);
`ifdef PACKET_ENCODER_ABORT_EN
        check("ur_abort_raw",   raw_vec[31:0], 32'hFF5AC380);
        check("ur_abort_nbits", raw_cnt,       32);
`else
        destuff();
        check("ur_ds_bits",  ds_cnt,        40);
        check("ur_stufferr", stuff_err,     0);
        check("ur_resid",    crc_resid(16), 16'h800D);
`endif

        // Reset in the middle of DATA
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h44; pay[3] = 8'h88;
        n_bytes = 4;
        n_avail = 4;
        start_pkt(4'h3, 1'b0);
        repeat (90) @(negedge clk48);
        check("mid_busy_before", tx_busy, 1'b1);
        reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        repeat (4) @(negedge clk48);
        check("mid_no_done", done_cnt, 0);
        check("mid_oe_held", tx_oe,    1'b0);
        reset  = 1'b1;
        mon_on = 1'b0;
        repeat (2) @(negedge clk48);

        n_bytes = 0;
        n_avail = 0;
        run_pkt(4'h2, 1'b0, -1);
        check("post_raw",     raw_vec[15:0], 16'hD280);
        check("post_done_at", done_n,        76);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
